operand_streamer: RTL and testbench

- Upstream stage of the streaming skewer. Fetches K operand vectors (N lanes each) from an operand SRAM with 1-cycle synchronous read latency and presents one vector per enabled cycle on vec_out/vec_en.
- vec_out/vec_en connect directly to skewer data_in/en.
- After the last real vector it appends N all-zero flush beats so that every skewed row drains into the systolic array, then pulses done.
- Downstream back-pressure (stall) freezes the skewer and the array; a 2-entry skid FIFO absorbs the read in flight.

---
 rtl/feeder_pkg.sv | 15 +
 rtl/feeder_skid_fifo.sv | 61 ++++++
 rtl/operand_streamer.sv | 152 +++++++++++++++
 tb/tb_operand_streamer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and constants for the operand streamer and its skid FIFO.
package feeder_pkg;

    // Streamer control states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } feeder_state_e;

    // Entries in the skid FIFO: one for the read in flight, one for the stalled head.
    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/feeder_skid_fifo.sv
// Two-entry synchronous FIFO of N-lane vectors that absorbs the SRAM read in flight
// while the downstream path is stalled.
module feeder_skid_fifo
    import feeder_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data [N],
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head [N],
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH][N];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < SKID_DEPTH; e++) begin
                for (int i = 0; i < N; i++) begin
                    mem_q[e][i] <= '0;
                end
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                for (int i = 0; i < N; i++) begin
                    mem_q[wr_ptr_q][i] <= push_data[i];
                end
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Head of queue is presented combinationally.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            head[i] = mem_q[rd_ptr_q][i];
        end
    end

    assign count = count_q;

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == 2'(SKID_DEPTH))));

    underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (count_q == 2'd0)));

endmodule

// File: rtl/operand_streamer.sv
// Operand streamer: reads K vectors from the operand SRAM, streams them to the skewer,
// appends N zero flush beats and pulses done. Stall freezes the output stream.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module operand_streamer
    import feeder_pkg::*;
#(
    parameter int unsigned N          = `ARRAY_SIZE,
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned K_WIDTH    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [K_WIDTH-1:0]    k_len,
    input  logic                  stall,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data [N],
    output logic [DATA_WIDTH-1:0] vec_out [N],
    output logic                  vec_en,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned FlushW = $clog2(N + 1);

    feeder_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [K_WIDTH-1:0]    klen_q, klen_d;
    logic [K_WIDTH-1:0]    issued_q, issued_d;
    logic [K_WIDTH-1:0]    popped_q, popped_d;
    logic [FlushW-1:0]     flush_q, flush_d;
    logic                  rd_pending_q;

    logic                  fifo_pop;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head [N];
    logic [2:0]            occupancy;

    feeder_skid_fifo #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending_q),
        .push_data (mem_rd_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Entries held plus the read whose data lands at the next edge.
    assign occupancy   = {1'b0, fifo_count} + {2'b0, rd_pending_q};
    assign mem_rd_addr = base_q + ADDR_WIDTH'(issued_q);

    // State and job registers; rd_pending tracks the 1-cycle SRAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            base_q       <= '0;
            klen_q       <= '0;
            issued_q     <= '0;
            popped_q     <= '0;
            flush_q      <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            klen_q       <= klen_d;
            issued_q     <= issued_d;
            popped_q     <= popped_d;
            flush_q      <= flush_d;
            rd_pending_q <= mem_rd_en;
        end
    end

    // Next-state, read issue and beat generation.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        klen_d    = klen_q;
        issued_d  = issued_q;
        popped_d  = popped_q;
        flush_d   = flush_q;
        mem_rd_en = 1'b0;
        vec_en    = 1'b0;
        fifo_pop  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d   = base_addr;
                    klen_d   = k_len;
                    issued_d = '0;
                    popped_d = '0;
                    flush_d  = '0;
                    state_d  = (k_len == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                busy     = 1'b1;
                vec_en   = (fifo_count != 2'd0) && !stall;
                fifo_pop = vec_en;
                // Only issue if the FIFO can still take the data after this cycle's pop.
                mem_rd_en = (issued_q < klen_q) && (occupancy < (3'd2 + {2'b0, fifo_pop}));
                if (mem_rd_en) begin
                    issued_d = issued_q + K_WIDTH'(1);
                end
                if (fifo_pop) begin
                    popped_d = popped_q + K_WIDTH'(1);
                    if (popped_q == klen_q - K_WIDTH'(1)) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                busy   = 1'b1;
                vec_en = !stall;
                if (vec_en) begin
                    flush_d = flush_q + FlushW'(1);
                    if (flush_q == FlushW'(N - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Flush beats are zero; otherwise the FIFO head is presented.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            vec_out[i] = (state_q == StFlush) ? '0 : fifo_head[i];
        end
    end

endmodule

// File: tb/tb_operand_streamer.sv
// Scoreboard bench for operand_streamer: the stimulus side predicts reads, beats and
// done from the job parameters; a monitor on the falling edge pops and compares.
module tb_operand_streamer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int KW = 10;
    localparam int NoJob = 1 << 30;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [KW-1:0] k_len;
    logic          stall;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data [N];
    logic [DW-1:0] vec_out [N];
    logic          vec_en;
    logic          busy;
    logic          done;

    logic [63:0] mem [1024];
    logic [63:0] rd_word = '0;
    logic [63:0] vo_flat;

    exp_t exp_rd[$];
    exp_t exp_beat[$];
    int   exp_done[$];
    int   exp_busy;

    int cyc = 0;
    int t0 = NoJob;
    int st_lo = -1;
    int st_hi = -1;
    int st_pct = 0;
    int busy_cnt = 0;
    int nchecks = 0;
    int nerrs = 0;

    operand_streamer #(
        .N          (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .K_WIDTH    (KW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .k_len       (k_len),
        .stall       (stall),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .vec_out     (vec_out),
        .vec_en      (vec_en),
        .busy        (busy),
        .done        (done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand SRAM model with one cycle of read latency.
    always @(posedge clk) if (mem_rd_en) rd_word <= mem[mem_rd_addr];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            mem_rd_data[i] = rd_word[i*DW +: DW];
            vo_flat[i*DW +: DW] = vec_out[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nchecks++;
        if (act !== req) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Stall driver: fixed window relative to the job start plus optional random stalls.
    initial begin
        int srel;
        stall = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            srel = cyc - t0;
            stall = (srel >= st_lo && srel <= st_hi) || (int'($urandom_range(99)) < st_pct);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reads, beats or finishes.
    initial begin
        int   rel;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                rel = cyc - t0;
                if (stall) check("no_beat_in_stall", 64'(vec_en), 64'd0);
                if (mem_rd_en) begin
                    check("read_expected", 64'(exp_rd.size() != 0), 64'd1);
                    if (exp_rd.size() != 0) begin
                        e = exp_rd.pop_front();
                        check("rd_addr", 64'(mem_rd_addr), e.val);
                        if (e.cyc >= 0) check("rd_cycle", 64'(rel), 64'(e.cyc));
                    end
                end
                if (vec_en) begin
                    check("beat_expected", 64'(exp_beat.size() != 0), 64'd1);
                    if (exp_beat.size() != 0) begin
                        e = exp_beat.pop_front();
                        check("beat_data", vo_flat, e.val);
                        if (e.cyc >= 0) check("beat_cycle", 64'(rel), 64'(e.cyc));
                    end
                end
                if (done) begin
                    check("done_expected", 64'(exp_done.size() != 0), 64'd1);
                    if (exp_done.size() != 0) begin
                        e.cyc = exp_done.pop_front();
                        if (e.cyc >= 0) check("done_cycle", 64'(rel), 64'(e.cyc));
                    end
                end
                if (busy) busy_cnt++;
            end
        end
    end

    // Reference model: k reads from base (wrapping), k data beats then N zero beats, done.
    // With timed=1, beats occupy consecutive non-stalled cycles starting at cycle 3.
    task automatic setup_expect(input int base, input int k, input bit timed, input int lo,
                                input int hi);
        int slot;
        int dcyc;
        exp_rd.delete();
        exp_beat.delete();
        exp_done.delete();
        for (int i = 0; i < k; i++) begin
            exp_rd.push_back('{64'((base + i) % 1024), (timed && lo < 0) ? i + 1 : -1});
        end
        slot = 3;
        if (k > 0) begin
            for (int j = 0; j < k + N; j++) begin
                while (slot >= lo && slot <= hi) slot++;
                exp_beat.push_back('{(j < k) ? mem[(base + j) % 1024] : 64'd0,
                                     timed ? slot : -1});
                slot++;
            end
        end
        dcyc = (k == 0) ? 1 : slot;
        exp_done.push_back(timed ? dcyc : -1);
        exp_busy = dcyc - 1;
    endtask

    task automatic launch(input int base, input int k);
        @(posedge clk);
        #1;
        busy_cnt  = 0;
        start     = 1'b1;
        base_addr = AW'(base);
        k_len     = KW'(k);
        t0        = cyc;
    endtask

    task automatic run_job(input int base, input int k, input bit timed, input int lo,
                           input int hi, input int pct, input bit extra);
        int rel;
        int guard;
        st_lo  = lo;
        st_hi  = hi;
        st_pct = pct;
        setup_expect(base, k, timed, lo, hi);
        launch(base, k);
        guard = 0;
        while (exp_done.size() != 0 && guard < 2000) begin
            @(posedge clk);
            #1;
            rel = cyc - t0;
            start     = extra && (rel == 2 || rel == 11);
            base_addr = AW'($urandom);
            k_len     = KW'($urandom_range(1, 1023));
            guard++;
        end
        start = 1'b0;
        check("done_seen", 64'(exp_done.size()), 64'd0);
        st_lo  = -1;
        st_hi  = -1;
        st_pct = 0;
        repeat (4) @(posedge clk);
        #1;
        check("reads_left", 64'(exp_rd.size()), 64'd0);
        check("beats_left", 64'(exp_beat.size()), 64'd0);
        if (timed) check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        t0 = NoJob;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        check({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
        check({tag, "_vec_out"}, vo_flat, 64'd0);
        check({tag, "_vec_en"}, 64'(vec_en), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        k_len     = '0;
        for (int a = 0; a < 1024; a++) mem[a] = {4{16'(a)}};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed jobs with exact cycle expectations.
        run_job(16'h010, 4, 1'b1, -1, -1, 0, 1'b0);
        run_job(16'h010, 4, 1'b1, 4, 6, 0, 1'b0);
        run_job(16'h000, 0, 1'b1, -1, -1, 0, 1'b0);
        run_job(16'h3FE, 3, 1'b1, -1, -1, 0, 1'b0);
        run_job(16'h010, 4, 1'b1, -1, -1, 0, 1'b1);

        // Reset in cycle 5 of a job, then a fresh job must behave as if nothing happened.
        setup_expect(16'h010, 4, 1'b1, -1, -1);
        launch(16'h010, 4);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        exp_rd.delete();
        exp_beat.delete();
        exp_done.delete();
        t0 = NoJob;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_job(16'h010, 4, 1'b1, -1, -1, 0, 1'b0);

        // Random contents, bases, lengths and stalls.
        for (int a = 0; a < 1024; a++) mem[a] = {$urandom, $urandom};
        for (int j = 0; j < 10; j++) begin
            run_job(int'($urandom_range(1023)), int'($urandom_range(12)), 1'b0, -1, -1, 30,
                    1'b0);
        end

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule
